fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction bus between the fetch queue (master) and the instruction memory path (slave).
interface fetch_queue_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic              data_ok;
      logic [INST_W-1:0] data;
   } ibus_resp_t;

   ibus_req_t  ireq;
   ibus_resp_t iresp;
   logic       iaddr_trans_finished;

   modport master (output ireq, input iresp, input iaddr_trans_finished);
   modport slave  (input ireq, output iresp, output iaddr_trans_finished);
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding bus request, DEPTH-entry instruction FIFO,
// redirect handling with response drop for requests made stale by a redirect.
module fetch_queue #(
   parameter logic [63:0] PCINIT = 64'h8000_0000,
   parameter int          DEPTH  = 4,
   parameter int          ADDR_W = 64,
   parameter int          INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   fetch_queue_if.master     ibus,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              csr_redirect,
   input  logic [ADDR_W-1:0] csr_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [INST_W-1:0] dec_inst,
   output logic [ADDR_W-1:0] dec_pc,
   output logic              idle
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t            state;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] fetch_pc;
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count;
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic              resp_acc, redir, push, pop;
   logic [ADDR_W-1:0] redir_pc;

   assign resp_acc = ibus.iresp.data_ok & ibus.iaddr_trans_finished;
   assign redir    = csr_redirect | redirect;
   assign redir_pc = csr_redirect ? csr_pc : redirect_pc;
   // A response landing together with a redirect is stale and must not enter the queue.
   assign push     = (state == S_REQ) & resp_acc & ~redir;
   assign pop      = dec_valid & dec_ready & ~redir;

   assign ibus.ireq = {req_valid, req_addr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         req_valid <= 1'b0;
         req_addr  <= '0;
         fetch_pc  <= ADDR_W'(PCINIT);
         head      <= '0;
         tail      <= '0;
         count     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!redir && count < DEPTH_C) begin
                  req_valid <= 1'b1;
                  req_addr  <= fetch_pc;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (resp_acc) begin
                  req_valid <= 1'b0;
                  state     <= S_IDLE;
               end else if (redir) begin
                  state <= S_DROP;
               end
            end
            S_DROP: begin
               if (resp_acc) begin
                  req_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               req_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase

         if (redir) begin
            fetch_pc <= redir_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               tail     <= tail + PTR_W'(1);
               fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (pop) head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_q[tail] <= ibus.iresp.data;
         pc_q[tail]   <= fetch_pc;
      end
   end

   assign dec_valid = (count != '0);
   assign dec_inst  = inst_q[head];
   assign dec_pc    = pc_q[head];
   assign idle      = (state == S_IDLE);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations, then randomized traffic,
// every cycle compared against a transaction-level model (request slot + instruction queue).
module tb_fetch_queue;
   localparam logic [63:0] PCINIT = 64'h8000_0000;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) ibus ();

   logic              redirect = 1'b0, csr_redirect = 1'b0, dec_ready = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0, csr_pc = '0;
   logic              dec_valid, idle;
   logic [INST_W-1:0] dec_inst;
   logic [ADDR_W-1:0] dec_pc;

   fetch_queue #(.PCINIT(PCINIT), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk(clk), .rst(rst), .ibus(ibus),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .csr_redirect(csr_redirect), .csr_pc(csr_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_inst(dec_inst), .dec_pc(dec_pc), .idle(idle)
   );

   int checks = 0;
   int errors = 0;

   // Model: one request slot (valid/addr/keep) plus a queue of fetched instructions.
   typedef struct {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } ent_t;
   ent_t              mq[$];
   logic [ADDR_W-1:0] m_fetch_pc = PCINIT;
   logic              m_valid = 1'b0;
   logic              m_keep  = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   bit                auto_bus = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_update();
      bit acc, rd, do_pop, can_issue;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_fetch_pc = PCINIT;
         m_valid    = 1'b0;
         m_keep     = 1'b0;
         return;
      end
      rd        = redirect || csr_redirect;
      acc       = m_valid && ibus.iresp.data_ok && ibus.iaddr_trans_finished;
      do_pop    = (mq.size() != 0) && dec_ready && !rd;
      can_issue = !m_valid && !rd && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (m_valid) begin
         if (acc) begin
            if (m_keep && !rd) begin
               e.inst = ibus.iresp.data;
               e.pc   = m_addr;
               mq.push_back(e);
               m_fetch_pc = m_fetch_pc + 64'd4;
            end
            m_valid = 1'b0;
         end else if (rd) begin
            m_keep = 1'b0;
         end
      end else if (can_issue) begin
         m_valid = 1'b1;
         m_addr  = m_fetch_pc;
         m_keep  = 1'b1;
      end
      if (rd) begin
         mq.delete();
         m_fetch_pc = csr_redirect ? csr_pc : redirect_pc;
      end
   endtask

   task automatic compare();
      check("ireq_valid", 64'(ibus.ireq.valid), 64'(m_valid));
      if (m_valid) check("ireq_addr", ibus.ireq.addr, m_addr);
      check("idle", 64'(idle), 64'(!m_valid));
      check("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("dec_pc", dec_pc, mq[0].pc);
         check("dec_inst", 64'(dec_inst), 64'(mq[0].inst));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare();
      if (auto_bus) begin
         ibus.iresp.data_ok        = m_valid;
         ibus.iaddr_trans_finished = 1'b1;
         ibus.iresp.data           = m_addr[31:0];
      end
   endtask

   logic [ADDR_W-1:0] req_addr [8];
   int nreq;

   initial begin
      ibus.iresp.data_ok        = 1'b0;
      ibus.iresp.data           = '0;
      ibus.iaddr_trans_finished = 1'b0;

      // Reset state
      step(); step();
      check("rst_ireq_valid", 64'(ibus.ireq.valid), 64'd0);
      check("rst_dec_valid", 64'(dec_valid), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);

      // Fill the queue with an immediately answering bus
      rst = 1'b0;
      auto_bus = 1'b1;
      nreq = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (ibus.ireq.valid && nreq < 8) begin
            req_addr[nreq] = ibus.ireq.addr;
            nreq++;
         end
      end
      check("fill_nreq", 64'(nreq), 64'd4);
      check("fill_req0", req_addr[0], 64'h8000_0000);
      check("fill_req1", req_addr[1], 64'h8000_0004);
      check("fill_req2", req_addr[2], 64'h8000_0008);
      check("fill_req3", req_addr[3], 64'h8000_000C);
      check("fill_head", dec_pc, 64'h8000_0000);
      check("fill_no_req", 64'(ibus.ireq.valid), 64'd0);

      // One pop from a full queue, then the next request issues
      auto_bus = 1'b0;
      ibus.iresp.data_ok = 1'b0;
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      check("pop_head", dec_pc, 64'h8000_0004);
      check("pop_no_req_yet", 64'(ibus.ireq.valid), 64'd0);
      step();
      check("refill_valid", 64'(ibus.ireq.valid), 64'd1);
      check("refill_addr", ibus.ireq.addr, 64'h8000_0010);

      // Redirect while in REQ: response dropped
      redirect = 1'b1;
      redirect_pc = 64'h8000_1000;
      step();
      redirect = 1'b0;
      check("redir_flush", 64'(dec_valid), 64'd0);
      check("redir_hold0", ibus.ireq.addr, 64'h8000_0010);
      for (int i = 0; i < 2; i++) begin
         step();
         check("redir_hold_v", 64'(ibus.ireq.valid), 64'd1);
         check("redir_hold", ibus.ireq.addr, 64'h8000_0010);
      end
      ibus.iresp.data_ok = 1'b1;
      ibus.iaddr_trans_finished = 1'b1;
      ibus.iresp.data = 32'hDEAD_BEEF;
      step();
      ibus.iresp.data_ok = 1'b0;
      check("drop_done", 64'(ibus.ireq.valid), 64'd0);
      check("drop_no_push", 64'(dec_valid), 64'd0);
      step();
      check("redir_req_addr", ibus.ireq.addr, 64'h8000_1000);
      check("redir_empty", 64'(dec_valid), 64'd0);

      // CSR redirect wins over redirect
      ibus.iresp.data_ok = 1'b1;
      ibus.iresp.data = 32'h1111_1111;
      step();
      ibus.iresp.data_ok = 1'b0;
      check("push_after_redir", dec_pc, 64'h8000_1000);
      csr_redirect = 1'b1; csr_pc = 64'h8000_2000;
      redirect = 1'b1; redirect_pc = 64'h8000_1000;
      step();
      csr_redirect = 1'b0; redirect = 1'b0;
      check("csr_no_issue", 64'(ibus.ireq.valid), 64'd0);
      check("csr_flush", 64'(dec_valid), 64'd0);
      step();
      check("csr_req_addr", ibus.ireq.addr, 64'h8000_2000);

      // Untranslated responses are ignored
      ibus.iresp.data_ok = 1'b1;
      ibus.iaddr_trans_finished = 1'b0;
      ibus.iresp.data = 32'h2222_2222;
      for (int i = 0; i < 2; i++) begin
         step();
         check("tf0_valid", 64'(ibus.ireq.valid), 64'd1);
         check("tf0_addr", ibus.ireq.addr, 64'h8000_2000);
         check("tf0_no_push", 64'(dec_valid), 64'd0);
      end
      ibus.iaddr_trans_finished = 1'b1;
      step();
      ibus.iresp.data_ok = 1'b0;
      check("tf1_push_pc", dec_pc, 64'h8000_2000);
      check("tf1_push_inst", 64'(dec_inst), 64'h2222_2222);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      check("tf_single_push", 64'(dec_valid), 64'd0);

      // Reset while in REQ with two entries queued
      ibus.iresp.data_ok = 1'b1; ibus.iresp.data = 32'h3333_3333;
      step();
      ibus.iresp.data_ok = 1'b0;
      step();
      ibus.iresp.data_ok = 1'b1; ibus.iresp.data = 32'h4444_4444;
      step();
      ibus.iresp.data_ok = 1'b0;
      step();
      check("pre_rst_valid", 64'(ibus.ireq.valid), 64'd1);
      check("pre_rst_head", dec_pc, 64'h8000_2004);
      rst = 1'b1;
      step();
      check("rst_req_dec_valid", 64'(dec_valid), 64'd0);
      check("rst_req_ireq_valid", 64'(ibus.ireq.valid), 64'd0);
      rst = 1'b0;
      step();
      check("post_rst_addr", ibus.ireq.addr, PCINIT);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 499) == 0);
         redirect     = ($urandom_range(0, 19) == 0);
         csr_redirect = ($urandom_range(0, 39) == 0);
         redirect_pc  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
         csr_pc       = 64'h9000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
         dec_ready    = ($urandom_range(0, 3) < (i / 1000));
         if (m_valid) begin
            ibus.iresp.data_ok        = ($urandom_range(0, 2) == 0);
            ibus.iaddr_trans_finished = ($urandom_range(0, 3) != 0);
            ibus.iresp.data           = $urandom;
         end else begin
            ibus.iresp.data_ok = 1'b0;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
